// File: rtl/enum_type.sv
// Shared enumerations used across the control blocks, plus a counter-width helper.
package enum_type;

  typedef enum logic [0:0] {StIdle, StRun} state_type;

  typedef enum logic [1:0] {
    RptIdle,
    RptDelay,
    RptRepeat,
    RptSuppressed
  } repeat_state_type;

  // Counter width able to reach max(a, b) - 1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/btn_repeat_channel.sv
// Per-button auto-repeat FSM: first pulse on press, optional repeats after DAS then every ARR.
module repeat_channel
  import enum_type::*;
#(
  parameter int unsigned DAS_CYCLES = 20_000_000,
  parameter int unsigned ARR_CYCLES = 5_000_000,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  input  logic press_edge,
  input  logic suppress,
  input  logic resume,
  input  logic enable,
  output logic pulse,
  output logic active
);

  localparam int unsigned CntW = cnt_width(DAS_CYCLES, ARR_CYCLES);
  localparam logic [CntW-1:0] DasLast = CntW'(DAS_CYCLES - 1);
  localparam logic [CntW-1:0] ArrLast = CntW'(ARR_CYCLES - 1);

  repeat_state_type state;
  logic [CntW-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RptIdle;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (!enable || !level) begin
        state <= RptIdle;
        cnt   <= '0;
      end else if (suppress) begin
        state <= RptSuppressed;
        cnt   <= '0;
      end else begin
        unique case (state)
          RptIdle: begin
            if (press_edge) begin
              pulse <= 1'b1;
              state <= RptDelay;
              cnt   <= '0;
            end
          end
          RptDelay: begin
            // Single-shot channels park here with the counter saturated until release.
            if (cnt == DasLast) begin
              if (REPEAT_EN) begin
                pulse <= 1'b1;
                state <= RptRepeat;
                cnt   <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RptRepeat: begin
            if (cnt == ArrLast) begin
              pulse <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RptSuppressed: begin
            if (resume) begin
              state <= RptDelay;
              cnt   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign active = (state != RptIdle);

endmodule

// File: rtl/btn_repeat.sv
// Four-channel button auto-repeat with RIGHT/LEFT (ch0/ch3) conflict arbitration.
module btn_repeat #(
  parameter int unsigned DAS_CYCLES  = 20_000_000,
  parameter int unsigned ARR_CYCLES  = 5_000_000,
  parameter logic [3:0]  REPEAT_MASK = 4'b1011
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn_level,
  input  logic       enable,
  output logic [3:0] pulse
);

  logic [3:0] prev;
  logic [3:0] press_edge;
  logic [3:0] suppress;
  logic [3:0] resume;
  logic [3:0] active;

  // Reset to all-held so buttons kept down through reset never look like fresh presses.
  always_ff @(posedge clk) begin
    if (!reset_n) prev <= 4'b1111;
    else          prev <= btn_level;
  end

  assign press_edge = btn_level & ~prev & {4{enable}};

  // Newest press wins the pair; on a same-cycle tie ch0 wins.
  always_comb begin
    suppress    = 4'b0000;
    resume      = 4'b0000;
    suppress[0] = press_edge[3] & active[0] & ~press_edge[0];
    suppress[3] = press_edge[0] & (active[3] | press_edge[3]);
    resume[0]   = ~btn_level[3];
    resume[3]   = ~btn_level[0];
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    repeat_channel #(
      .DAS_CYCLES(DAS_CYCLES),
      .ARR_CYCLES(ARR_CYCLES),
      .REPEAT_EN (REPEAT_MASK[i])
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .level     (btn_level[i]),
      .press_edge(press_edge[i]),
      .suppress  (suppress[i]),
      .resume    (resume[i]),
      .enable    (enable),
      .pulse     (pulse[i]),
      .active    (active[i])
    );
  end

endmodule
